// File: rtl/regfiletmp_ctrl.sv
// ============================================================================
// Module   : regfiletmp_ctrl
// Brief    : In-order alloc/commit controller for the regfiletmp speculative RF
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfiletmp_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 73
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          alloc_req,
  input  logic [4:0]    alloc_rd,
  input  logic [31:0]   alloc_pc,
  input  logic [1:0]    alloc_type,
  output logic          alloc_gnt,
  output logic [AW-1:0] alloc_tag,
  output logic          full,
  output logic          empty,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_tag,
  input  logic [31:0]   wb_data,
  input  logic [AW-1:0] lookup_tag,
  output logic          lookup_ready,
  output logic [31:0]   lookup_data,
  input  logic          mispredict,
  output logic          commit_valid,
  output logic [4:0]    commit_rd,
  output logic [31:0]   commit_data,
  output logic [DW-1:0] rf_data_in,
  output logic [AW-1:0] rf_waddr,
  output logic          rf_new_entry,
  output logic          rf_update,
  output logic          rf_flush,
  output logic [AW-1:0] rf_rd_addr1,
  input  logic [DW-1:0] rf_data_out1,
  output logic [AW-1:0] rf_rd_addr2,
  input  logic [DW-1:0] rf_data_out2
);

  localparam logic [AW:0] c_depth = DEPTH[AW:0];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic [AW-1:0] w_wb_dist;
  logic          w_wb_inwin;
  logic          w_wb_steal;
  logic          w_unused;

  // Distance from head wraps naturally in AW bits, giving the circular window test.
  assign w_wb_dist  = wb_tag - r_head;
  assign w_wb_inwin = ({1'b0, w_wb_dist} < r_count);
  assign w_wb_steal = wb_valid & w_wb_inwin;

  assign full  = (r_count == c_depth);
  assign empty = (r_count == '0);

  assign rf_flush     = reset & mispredict;
  assign rf_update    = reset & w_wb_steal & ~mispredict;
  assign alloc_gnt    = reset & alloc_req & ~full & ~rf_update & ~mispredict;
  assign rf_new_entry = alloc_gnt;
  assign alloc_tag    = r_tail;

  assign rf_rd_addr1  = r_head;
  assign rf_rd_addr2  = w_wb_steal ? wb_tag : lookup_tag;

  assign commit_valid = reset & ~empty & rf_data_out1[0] & rf_data_out1[1] & ~mispredict;
  assign commit_rd    = rf_data_out1[72:68];
  assign commit_data  = rf_data_out1[33:2];

  assign lookup_ready = rf_data_out2[0] & rf_data_out2[1];
  assign lookup_data  = rf_data_out2[33:2];

  // Writeback keeps the stored rd/PC/type, read back through the stolen port 2.
  assign rf_waddr   = rf_update ? wb_tag : r_tail;
  assign rf_data_in = rf_update ? {rf_data_out2[72:34], wb_data, 2'b11}
                                : {alloc_rd, alloc_pc, alloc_type, 32'b0, 2'b01};

  assign w_unused = ^rf_data_out1[67:34];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (mispredict) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (commit_valid) r_head <= r_head + AW'(1);
      if (alloc_gnt)    r_tail <= r_tail + AW'(1);
      r_count <= r_count + (AW+1)'(alloc_gnt) - (AW+1)'(commit_valid);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfiletmp_ctrl.sv
// Bench for regfiletmp_ctrl: a regfiletmp stand-in, an entry-level reference model
// checked every cycle, plus directed literal checks and a randomized phase.
`default_nettype none

module tb_regfiletmp_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alloc_req = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic [31:0] alloc_pc = '0;
  logic [1:0]  alloc_type = '0;
  logic        alloc_gnt;
  logic [4:0]  alloc_tag;
  logic        full, empty;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_tag = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  lookup_tag = '0;
  logic        lookup_ready;
  logic [31:0] lookup_data;
  logic        mispredict = 1'b0;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [72:0] rf_data_in;
  logic [4:0]  rf_waddr;
  logic        rf_new_entry, rf_update, rf_flush;
  logic [4:0]  rf_rd_addr1, rf_rd_addr2;
  logic [72:0] rf_data_out1, rf_data_out2;

  int n_chk = 0;
  int n_err = 0;

  regfiletmp_ctrl #(.DEPTH(32), .AW(5), .DW(73)) dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_type(alloc_type),
    .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag), .full(full), .empty(empty),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .lookup_tag(lookup_tag), .lookup_ready(lookup_ready), .lookup_data(lookup_data),
    .mispredict(mispredict), .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_data(commit_data), .rf_data_in(rf_data_in), .rf_waddr(rf_waddr),
    .rf_new_entry(rf_new_entry), .rf_update(rf_update), .rf_flush(rf_flush),
    .rf_rd_addr1(rf_rd_addr1), .rf_data_out1(rf_data_out1),
    .rf_rd_addr2(rf_rd_addr2), .rf_data_out2(rf_data_out2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // regfiletmp stand-in: synchronous write, combinational reads, flush drops validity
  logic [72:0] mem [32];
  assign rf_data_out1 = mem[rf_rd_addr1];
  assign rf_data_out2 = mem[rf_rd_addr2];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (rf_flush) begin
      for (int i = 0; i < 32; i++) mem[i][1:0] <= 2'b00;
    end else if (rf_update || rf_new_entry) begin
      mem[rf_waddr] <= rf_data_in;
    end
  end

  // Reference model: per-entry fields and circular queue bookkeeping
  int          m_head, m_tail, m_count;
  bit          m_v [32];
  bit          m_sv[32];
  logic [4:0]  m_rd[32];
  logic [31:0] m_pc[32];
  logic [1:0]  m_ty[32];
  logic [31:0] m_dat[32];
  bit          e_upd, e_gnt, e_commit, e_steal;

  always @(negedge clock) begin
    int  t, lt;
    bit  inwin, e_full;
    t      = int'(wb_tag);
    lt     = int'(lookup_tag);
    inwin  = ((t - m_head + 32) % 32) < m_count;
    e_steal  = wb_valid && inwin;
    e_upd    = reset && e_steal && !mispredict;
    e_full   = (m_count == 32);
    e_gnt    = reset && alloc_req && !e_full && !e_upd && !mispredict;
    e_commit = reset && m_count > 0 && m_v[m_head] && m_sv[m_head] && !mispredict;

    chk("alloc_gnt", alloc_gnt, e_gnt);
    chk("rf_new_entry", rf_new_entry, e_gnt);
    chk("rf_update", rf_update, e_upd);
    chk("rf_flush", rf_flush, reset && mispredict);
    chk("commit_valid", commit_valid, e_commit);
    chk("full", full, e_full);
    chk("empty", empty, m_count == 0);
    chk("alloc_tag", alloc_tag, 73'(m_tail));
    chk("rf_rd_addr1", rf_rd_addr1, 73'(m_head));
    chk("rf_rd_addr2", rf_rd_addr2, e_steal ? 73'(t) : 73'(lt));
    if (e_upd) begin
      chk("upd_waddr", rf_waddr, 73'(t));
      chk("upd_data_in", rf_data_in, {m_rd[t], m_pc[t], m_ty[t], wb_data, 2'b11});
    end
    if (e_gnt) begin
      chk("alloc_waddr", rf_waddr, 73'(m_tail));
      chk("alloc_data_in", rf_data_in, {alloc_rd, alloc_pc, alloc_type, 32'b0, 2'b01});
    end
    if (e_commit) begin
      chk("commit_rd", commit_rd, m_rd[m_head]);
      chk("commit_data", commit_data, m_dat[m_head]);
    end
    if (!e_steal) begin
      chk("lookup_ready", lookup_ready, m_v[lt] && m_sv[lt]);
      if (m_v[lt] && m_sv[lt]) chk("lookup_data", lookup_data, m_dat[lt]);
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_head = 0; m_tail = 0; m_count = 0;
      for (int i = 0; i < 32; i++) begin
        m_v[i] = 0; m_sv[i] = 0; m_rd[i] = '0; m_pc[i] = '0; m_ty[i] = '0; m_dat[i] = '0;
      end
    end else if (mispredict) begin
      m_head = 0; m_tail = 0; m_count = 0;
      for (int i = 0; i < 32; i++) begin m_v[i] = 0; m_sv[i] = 0; end
    end else begin
      if (e_upd) begin
        m_dat[wb_tag] = wb_data; m_sv[wb_tag] = 1; m_v[wb_tag] = 1;
      end
      if (e_gnt) begin
        m_rd[m_tail] = alloc_rd; m_pc[m_tail] = alloc_pc; m_ty[m_tail] = alloc_type;
        m_dat[m_tail] = '0; m_sv[m_tail] = 0; m_v[m_tail] = 1;
        m_tail = (m_tail + 1) % 32;
      end
      if (e_commit) m_head = (m_head + 1) % 32;
      m_count = m_count + int'(e_gnt) - int'(e_commit);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req = 0; wb_valid = 0; mispredict = 0;
  endtask

  initial begin
    // strobes must stay low while reset is held, even with every request asserted
    alloc_req = 1; wb_valid = 1; mispredict = 1;
    step(); #1;
    chk("rst_empty", empty, 1);
    chk("rst_strobes", {rf_new_entry, rf_update, rf_flush, alloc_gnt, commit_valid}, 0);
    step();
    idle_inputs();
    reset = 1;
    #1;
    chk("init_tag", alloc_tag, 0);
    chk("init_empty", empty, 1);

    // fill all 32 entries
    alloc_req = 1;
    for (int i = 0; i < 32; i++) begin
      alloc_rd = 5'(i); alloc_pc = 32'h1000 + 32'(4 * i); alloc_type = 2'(i);
      #1;
      chk("fill_gnt", alloc_gnt, 1);
      chk("fill_tag", alloc_tag, 73'(i));
      step();
    end
    #1;
    chk("fill_full", full, 1);
    chk("fill_over_gnt", alloc_gnt, 0);
    alloc_req = 0;

    // writeback head entry, commit next cycle
    wb_valid = 1; wb_tag = 0; wb_data = 32'hA5;
    #1;
    chk("wb0_update", rf_update, 1);
    chk("wb0_waddr", rf_waddr, 0);
    step();
    wb_valid = 0;
    #1;
    chk("wb0_commit", commit_valid, 1);
    chk("wb0_cdata", commit_data, 32'hA5);
    chk("wb0_crd", commit_rd, 0);
    step(); #1;
    chk("wb0_head", rf_rd_addr1, 1);
    chk("wb0_notfull", full, 0);

    // writeback wins the port over a same-cycle alloc
    alloc_req = 1; alloc_rd = 5'd7; wb_valid = 1; wb_tag = 3; wb_data = 32'h55;
    #1;
    chk("arb_update", rf_update, 1);
    chk("arb_waddr", rf_waddr, 3);
    chk("arb_gnt", alloc_gnt, 0);
    step();
    wb_valid = 0;
    #1;
    chk("arb_gnt_next", alloc_gnt, 1);
    chk("arb_tag_next", alloc_tag, 0);
    step();
    alloc_req = 0;

    // flush, then mispredict with an eligible head and count = 12
    mispredict = 1; step(); mispredict = 0;
    alloc_req = 1; repeat (12) step(); alloc_req = 0;
    wb_valid = 1; wb_tag = 0; wb_data = 32'h1234; step(); wb_valid = 0;
    mispredict = 1;
    #1;
    chk("mp_flush", rf_flush, 1);
    chk("mp_commit", commit_valid, 0);
    step();
    mispredict = 0;
    #1;
    chk("mp_empty", empty, 1);
    chk("mp_head", rf_rd_addr1, 0);
    chk("mp_tail", alloc_tag, 0);

    // out-of-window writeback is dropped
    alloc_req = 1; repeat (4) step(); alloc_req = 0;
    wb_valid = 1; wb_tag = 9; wb_data = 32'hFF; lookup_tag = 5'd2;
    #1;
    chk("drop_update", rf_update, 0);
    chk("drop_addr2", rf_rd_addr2, 2);
    step();
    wb_valid = 0;
    #1;
    chk("drop_tail", alloc_tag, 4);
    chk("drop_head", rf_rd_addr1, 0);
    chk("drop_nonempty", empty, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      alloc_req  = $urandom_range(0, 99) < ((i < 1500) ? 60 : 30);
      alloc_rd   = 5'($urandom);
      alloc_pc   = $urandom;
      alloc_type = 2'($urandom);
      wb_valid   = $urandom_range(0, 99) < 50;
      wb_tag     = 5'((m_head + int'($urandom_range(0, m_count + 2))) % 32);
      wb_data    = $urandom;
      lookup_tag = 5'($urandom);
      mispredict = $urandom_range(0, 99) < 2;
      step();
    end

    // asynchronous reset mid-run with count = 7
    idle_inputs();
    mispredict = 1; step(); mispredict = 0;
    alloc_req = 1; repeat (7) step(); alloc_req = 0;
    #1;
    reset = 0;
    alloc_req = 1; wb_valid = 1; wb_tag = 0; mispredict = 1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_head", rf_rd_addr1, 0);
    chk("arst_tail", alloc_tag, 0);
    chk("arst_strobes", {rf_new_entry, rf_update, rf_flush, alloc_gnt, commit_valid}, 0);
    step();
    idle_inputs();
    reset = 1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
